// File: rtl/stream_crossbar_switch.sv
// stream_crossbar_switch: registered S-to-M AXI-Stream crossbar.
// Each source steers beats by s_dest_i. Every output has its own round-robin arbiter that
// locks to one source from a packet's first accepted beat until its last beat is accepted,
// followed by a 2-entry skid slice, so no m_ready_i -> s_ready_o combinational path exists.
// Beats addressed to a non-existent output are accepted and discarded.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   s_data_i   in   S x T_DATA_WIDTH source data (source s at [s*T_DATA_WIDTH +: T_DATA_WIDTH])
//   s_dest_i   in   S x T_DEST_WIDTH target output index
//   s_last_i   in   S   last beat of packet
//   s_valid_i  in   S   source beat valid
//   s_ready_o  out  S   beat accepted when valid & ready
//   m_data_o   out  M x T_DATA_WIDTH registered output data
//   m_id_o     out  M x T_ID___WIDTH originating source index
//   m_last_o   out  M   last beat of packet
//   m_valid_o  out  M   output beat valid
//   m_ready_i  in   M   sink ready
module stream_crossbar_switch #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned S_DATA_COUNT = 2,
  parameter int unsigned M_DATA_COUNT = 3,
  parameter int unsigned T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
  parameter int unsigned T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT*T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
  output logic [M_DATA_COUNT-1:0]              m_last_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i
);

  localparam int unsigned DW = T_DATA_WIDTH;
  localparam int unsigned IW = T_ID___WIDTH;
  localparam int unsigned TW = T_DEST_WIDTH;
  localparam int unsigned S  = S_DATA_COUNT;
  localparam int unsigned M  = M_DATA_COUNT;

  localparam logic StIdle   = 1'b0;
  localparam logic StLocked = 1'b1;

  // Held low through reset and the first cycle after it so s_ready_o is 0 while in reset.
  logic en_q;

  logic [S-1:0]    req [M];
  logic [M-1:0]    gnt_vld;
  logic [IW-1:0]   gnt_id [M];
  logic [DW-1:0]   sel_data [M];
  logic [M-1:0]    sel_last;
  logic [M-1:0]    in_rdy;
  logic [M-1:0]    push;

  logic [M-1:0]    state_q;
  logic [IW-1:0]   lock_q [M];
  logic [IW-1:0]   rr_q [M];

  logic [M-1:0]    main_vld_q;
  logic [DW-1:0]   main_data_q [M];
  logic [IW-1:0]   main_id_q [M];
  logic [M-1:0]    main_last_q;
  logic [M-1:0]    skid_full_q;
  logic [DW-1:0]   skid_data_q [M];
  logic [IW-1:0]   skid_id_q [M];
  logic [M-1:0]    skid_last_q;

  // Request matrix, arbitration and input-side mux per output.
  always_comb begin
    for (int unsigned m = 0; m < M; m++) begin
      for (int unsigned s = 0; s < S; s++) begin
        req[m][s] = s_valid_i[s] && (32'(s_dest_i[s*TW +: TW]) == m);
      end
      gnt_vld[m] = 1'b0;
      gnt_id[m]  = '0;
      if (state_q[m] == StLocked) begin
        gnt_id[m]  = lock_q[m];
        gnt_vld[m] = req[m][lock_q[m]];
      end else begin
        // Scan from farthest to nearest offset after rr_q so the nearest requester wins.
        for (int unsigned i = S; i >= 1; i--) begin
          for (int unsigned s = 0; s < S; s++) begin
            if (req[m][s] && (((32'(rr_q[m]) + i) % S) == s)) begin
              gnt_vld[m] = 1'b1;
              gnt_id[m]  = IW'(s);
            end
          end
        end
      end
      sel_data[m] = '0;
      sel_last[m] = 1'b0;
      for (int unsigned s = 0; s < S; s++) begin
        if (gnt_id[m] == IW'(s)) begin
          sel_data[m] = s_data_i[s*DW +: DW];
          sel_last[m] = s_last_i[s];
        end
      end
      in_rdy[m] = en_q & ~skid_full_q[m];
      push[m]   = gnt_vld[m] & in_rdy[m];
    end
  end

  // Source ready: granted on its destination, or sinking a beat to a non-existent output.
  always_comb begin
    for (int unsigned s = 0; s < S; s++) begin
      s_ready_o[s] = 1'b0;
      if (32'(s_dest_i[s*TW +: TW]) >= M) begin
        s_ready_o[s] = en_q;
      end else begin
        for (int unsigned m = 0; m < M; m++) begin
          if ((32'(s_dest_i[s*TW +: TW]) == m) && gnt_vld[m] && (gnt_id[m] == IW'(s))) begin
            s_ready_o[s] = in_rdy[m];
          end
        end
      end
    end
  end

  // Arbiter state: lock on a non-last accepted beat, release and advance rr on a last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      for (int unsigned m = 0; m < M; m++) begin
        state_q[m] <= StIdle;
        lock_q[m]  <= '0;
        rr_q[m]    <= IW'(S - 1);
      end
    end else begin
      en_q <= 1'b1;
      for (int unsigned m = 0; m < M; m++) begin
        if (push[m]) begin
          if (sel_last[m]) begin
            state_q[m] <= StIdle;
            rr_q[m]    <= gnt_id[m];
          end else begin
            state_q[m] <= StLocked;
            lock_q[m]  <= gnt_id[m];
          end
        end
      end
    end
  end

  // Skid slice: the skid register only fills when main is held and a beat still arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_q  <= '0;
      main_last_q <= '0;
      skid_full_q <= '0;
      skid_last_q <= '0;
      for (int unsigned m = 0; m < M; m++) begin
        main_data_q[m] <= '0;
        main_id_q[m]   <= '0;
        skid_data_q[m] <= '0;
        skid_id_q[m]   <= '0;
      end
    end else begin
      for (int unsigned m = 0; m < M; m++) begin
        if (!main_vld_q[m] || m_ready_i[m]) begin
          if (skid_full_q[m]) begin
            main_vld_q[m]  <= 1'b1;
            main_data_q[m] <= skid_data_q[m];
            main_id_q[m]   <= skid_id_q[m];
            main_last_q[m] <= skid_last_q[m];
            skid_full_q[m] <= 1'b0;
          end else begin
            main_vld_q[m] <= push[m];
            if (push[m]) begin
              main_data_q[m] <= sel_data[m];
              main_id_q[m]   <= gnt_id[m];
              main_last_q[m] <= sel_last[m];
            end
          end
        end else if (push[m]) begin
          skid_full_q[m] <= 1'b1;
          skid_data_q[m] <= sel_data[m];
          skid_id_q[m]   <= gnt_id[m];
          skid_last_q[m] <= sel_last[m];
        end
      end
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_out
    assign m_data_o[m*DW +: DW] = main_data_q[m];
    assign m_id_o[m*IW +: IW]   = main_id_q[m];
  end
  assign m_last_o  = main_last_q;
  assign m_valid_o = main_vld_q;

endmodule

// File: tb/tb_stream_crossbar_switch.sv
// Directed bench for stream_crossbar_switch (T_DATA_WIDTH=8, S=2, M=3).
module tb_stream_crossbar_switch;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] s_data_i;
  logic [3:0]  s_dest_i;
  logic [1:0]  s_last_i;
  logic [1:0]  s_valid_i;
  logic [1:0]  s_ready_o;
  logic [23:0] m_data_o;
  logic [2:0]  m_id_o;
  logic [2:0]  m_last_o;
  logic [2:0]  m_valid_o;
  logic [2:0]  m_ready_i;

  logic [7:0] sd [2];
  logic [1:0] sdst [2];
  logic [1:0] sv;
  logic [1:0] sl;
  logic [2:0] mr;

  assign s_data_i  = {sd[1], sd[0]};
  assign s_dest_i  = {sdst[1], sdst[0]};
  assign s_last_i  = sl;
  assign s_valid_i = sv;
  assign m_ready_i = mr;

  stream_crossbar_switch #(
    .T_DATA_WIDTH(8),
    .S_DATA_COUNT(2),
    .M_DATA_COUNT(3)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_data_i (s_data_i),
    .s_dest_i (s_dest_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_id_o   (m_id_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] d;
    logic [1:0] dest;
    logic       last;
  } beat_t;

  typedef struct {
    int         port;
    logic [7:0] d;
    logic       id;
    logic       last;
    int         cyc;
  } obs_t;

  beat_t src0_q[$];
  beat_t src1_q[$];
  obs_t  obs_q[$];
  int    n_cmp;
  int    n_bad;
  int    stall_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives queued beats, records every output transfer with its cycle index.
  task automatic run(input int max_cyc, input int stall_start, input int stall_len,
                     input logic [7:0] stall_data);
    int         cyc;
    logic [1:0] acc;
    beat_t      b;
    cyc = 0;
    obs_q.delete();
    stall_acc = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || m_valid_o != 3'b000) && cyc < max_cyc) begin
      if (src0_q.size() != 0) begin
        b = src0_q[0]; sv[0] = 1'b1; sd[0] = b.d; sdst[0] = b.dest; sl[0] = b.last;
      end else sv[0] = 1'b0;
      if (src1_q.size() != 0) begin
        b = src1_q[0]; sv[1] = 1'b1; sd[1] = b.d; sdst[1] = b.dest; sl[1] = b.last;
      end else sv[1] = 1'b0;
      mr = 3'b111;
      if (cyc >= stall_start && cyc < stall_start + stall_len) mr[0] = 1'b0;
      @(negedge clk_i);
      for (int m = 0; m < 3; m++) begin
        if (m_valid_o[m] && mr[m])
          obs_q.push_back('{port: m, d: m_data_o[m*8 +: 8], id: m_id_o[m], last: m_last_o[m],
                            cyc: cyc});
      end
      if (!mr[0]) begin
        check($sformatf("stall_hold_c%0d", cyc), {24'd0, m_data_o[7:0]}, {24'd0, stall_data});
        if (s_valid_i[0] && s_ready_o[0]) stall_acc++;
      end
      acc = s_valid_i & s_ready_o;
      tick();
      if (acc[0]) void'(src0_q.pop_front());
      if (acc[1]) void'(src1_q.pop_front());
      cyc++;
    end
    sv = 2'b00;
    mr = 3'b111;
    check("run_in_budget", {31'd0, cyc < max_cyc}, 32'd1);
  endtask

  task automatic expect_obs(input int i, input int port, input logic [7:0] d, input logic id,
                            input logic last, input int cyc);
    if (i >= obs_q.size()) begin
      check($sformatf("obs%0d_count", i), obs_q.size(), i + 1);
    end else begin
      check($sformatf("obs%0d_port", i), obs_q[i].port, port);
      check($sformatf("obs%0d_data", i), {24'd0, obs_q[i].d}, {24'd0, d});
      check($sformatf("obs%0d_id", i), {31'd0, obs_q[i].id}, {31'd0, id});
      check($sformatf("obs%0d_last", i), {31'd0, obs_q[i].last}, {31'd0, last});
      check($sformatf("obs%0d_cyc", i), obs_q[i].cyc, cyc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_ni = 1'b0;
    sv = 2'b00; sl = 2'b00; mr = 3'b111;
    sd[0] = '0; sd[1] = '0; sdst[0] = '0; sdst[1] = '0;

    // Reset state.
    #2;
    check("rst_m_valid", {29'd0, m_valid_o}, 32'd0);
    check("rst_m_data", {8'd0, m_data_o}, 32'd0);
    check("rst_s_ready", {30'd0, s_ready_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    tick();

    // 1: src1 locks output 1 with a partial packet, reset mid-packet, then arbitration restarts.
    sv = 2'b10; sdst[1] = 2'd1; sd[1] = 8'h10; sl = 2'b00;
    @(negedge clk_i);
    check("t1_first_rdy", {30'd0, s_ready_o}, 32'b10);
    tick(); sd[1] = 8'h11;
    tick(); sd[1] = 8'h12;
    tick(); sd[1] = 8'h13;
    @(negedge clk_i);
    check("t1_mid_valid", {29'd0, m_valid_o}, 32'b010);
    check("t1_mid_data", {24'd0, m_data_o[15:8]}, 32'h12);
    rst_ni = 1'b0;
    #1;
    check("t1_rst_valid", {29'd0, m_valid_o}, 32'd0);
    check("t1_rst_ready", {30'd0, s_ready_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    sv = 2'b11; sdst[0] = 2'd1; sdst[1] = 2'd1; sd[0] = 8'h20; sd[1] = 8'h21; sl = 2'b11;
    tick();
    @(negedge clk_i);
    check("t1_src0_wins", {30'd0, s_ready_o}, 32'b01);
    check("t1_empty_after_rst", {29'd0, m_valid_o}, 32'd0);
    tick();
    @(negedge clk_i);
    check("t1_src1_next", {30'd0, s_ready_o}, 32'b10);
    check("t1_out_valid", {29'd0, m_valid_o}, 32'b010);
    check("t1_out_data0", {24'd0, m_data_o[15:8]}, 32'h20);
    check("t1_out_id0", {31'd0, m_id_o[1]}, 32'd0);
    tick();
    sv = 2'b00;
    @(negedge clk_i);
    check("t1_out_data1", {24'd0, m_data_o[15:8]}, 32'h21);
    check("t1_out_id1", {31'd0, m_id_o[1]}, 32'd1);
    tick();
    @(negedge clk_i);
    check("t1_drained", {29'd0, m_valid_o}, 32'd0);
    tick();

    // 2: two 4-beat packets to output 2, no interleaving, back-to-back.
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back('{d: 8'hA0 + 8'(i), dest: 2'd2, last: (i == 3)});
      src1_q.push_back('{d: 8'hB0 + 8'(i), dest: 2'd2, last: (i == 3)});
    end
    run(60, -1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      expect_obs(i, 2, 8'hA0 + 8'(i), 1'b0, (i == 3), 1 + i);
      expect_obs(4 + i, 2, 8'hB0 + 8'(i), 1'b1, (i == 3), 5 + i);
    end

    // 3: single-beat packets from both sources to output 0 alternate.
    src0_q.push_back('{d: 8'h30, dest: 2'd0, last: 1'b1});
    src0_q.push_back('{d: 8'h31, dest: 2'd0, last: 1'b1});
    src1_q.push_back('{d: 8'h40, dest: 2'd0, last: 1'b1});
    src1_q.push_back('{d: 8'h41, dest: 2'd0, last: 1'b1});
    run(60, -1, 0, 8'h00);
    expect_obs(0, 0, 8'h30, 1'b0, 1'b1, 1);
    expect_obs(1, 0, 8'h40, 1'b1, 1'b1, 2);
    expect_obs(2, 0, 8'h31, 1'b0, 1'b1, 3);
    expect_obs(3, 0, 8'h41, 1'b1, 1'b1, 4);

    // 4: output 0 stalled for cycles 3..7 of an 8-beat stream.
    for (int i = 0; i < 8; i++) src0_q.push_back('{d: 8'h50 + 8'(i), dest: 2'd0, last: (i == 7)});
    run(80, 3, 5, 8'h52);
    check("t4_stall_accepts", stall_acc, 32'd1);
    expect_obs(0, 0, 8'h50, 1'b0, 1'b0, 1);
    expect_obs(1, 0, 8'h51, 1'b0, 1'b0, 2);
    expect_obs(2, 0, 8'h52, 1'b0, 1'b0, 8);
    for (int i = 3; i < 8; i++) expect_obs(i, 0, 8'h50 + 8'(i), 1'b0, (i == 7), 6 + i);
    check("t4_obs_total", obs_q.size(), 32'd8);

    // 5: parallel paths src0->out0 and src1->out1.
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back('{d: 8'h80 + 8'(i), dest: 2'd0, last: (i == 3)});
      src1_q.push_back('{d: 8'h90 + 8'(i), dest: 2'd1, last: (i == 3)});
    end
    run(60, -1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      expect_obs(2 * i, 0, 8'h80 + 8'(i), 1'b0, (i == 3), 1 + i);
      expect_obs(2 * i + 1, 1, 8'h90 + 8'(i), 1'b1, (i == 3), 1 + i);
    end

    // 6: out-of-range destination is sunk without touching any output or arbiter.
    sv = 2'b01; sdst[0] = 2'd3; sd[0] = 8'h60; sl = 2'b01;
    @(negedge clk_i);
    check("t6_ready", {30'd0, s_ready_o}, 32'b01);
    check("t6_no_valid0", {29'd0, m_valid_o}, 32'd0);
    tick();
    sv = 2'b00;
    @(negedge clk_i);
    check("t6_no_valid1", {29'd0, m_valid_o}, 32'd0);
    tick();
    src0_q.push_back('{d: 8'h61, dest: 2'd2, last: 1'b1});
    src1_q.push_back('{d: 8'h71, dest: 2'd2, last: 1'b1});
    run(40, -1, 0, 8'h00);
    expect_obs(0, 2, 8'h61, 1'b0, 1'b1, 1);
    expect_obs(1, 2, 8'h71, 1'b1, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
